avalon_slave_mem: RTL and testbench
===================================

Name: avalon_slave_mem

Overview:
- Synthesizable Avalon-MM slave: a register-file memory with a programmable number of wait states.
- Sits directly downstream of the team's Avalon master driver and answers its m_write/m_read tasks through the waitrequest handshake.
- Also detects protocol violations by the master, returns an Avalon response code, and counts completed transfers.

Parameters:
AW, 8, address width in words
DW, 32, data width; must be a multiple of 8
DEPTH, 2**AW, number of implemented words; addresses >= DEPTH decode-error
WAIT_CYCLES, 2, cycles waitrequest stays high after the command is captured (0..15)

Ports:
clk  input  1  single clock; all logic on posedge
reset_n  input  1  asynchronous, active-low reset
address  input  AW  word address from master
read  input  1  read request
write  input  1  write request
writedata  input  DW  write data
byteenable  input  DW/8  per-byte write enable (ignored for reads)
readdata  output  DW  read data, valid while waitrequest=0 on a read
waitrequest  output  1  high = slave stalling/idle; low one cycle = transfer accepted
response  output  2  00 OKAY, 10 SLVERR, 11 DECODEERROR; valid with waitrequest=0
proto_err  output  1  sticky: master changed address/command/data while stalled, or read&write together
wr_count  output  16  completed OKAY writes, saturating at 16'hFFFF
rd_count  output  16  completed OKAY reads, saturating at 16'hFFFF

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - waitrequest=1, readdata=0, response=00, proto_err=0, counters=0.
  - All DEPTH words cleared to 0.
  - FSM returns to IDLE; any in-flight transfer is dropped with no memory write.
- Waitrequest is high in every state except ACK. The master therefore always sees a falling edge of waitrequest per transfer.
- FSM states:
  - IDLE: on a posedge with read|write high, capture address, command, writedata and byteenable. Load wait counter = WAIT_CYCLES. Go to WAIT, or directly to ACK if WAIT_CYCLES=0.
  - WAIT: decrement counter each cycle. When counter reaches 1 (or is 0 on entry), go to ACK.
  - ACK: waitrequest=0 for exactly one cycle.
    - At the closing posedge, a write is committed to memory per byteenable and counters update.
    - Go to IDLE unconditionally.
    - The command still high at this edge is the accepted one and is never re-captured.
    - A fresh command is recognised from the next posedge.
- Latency: command seen at edge N -> waitrequest low during cycle N+WAIT_CYCLES+1 -> accepted at its end. Minimum is one stall cycle; waitrequest is always registered, never combinational.
- Reads:
  - readdata and response are registered on entry to ACK from the captured address.
  - readdata holds its value until the next read enters ACK.
  - Writes do not disturb readdata.
- Response decode, evaluated at capture:
  - read&write both high -> SLVERR: no access, proto_err set.
  - Captured address >= DEPTH -> DECODEERROR: write dropped, readdata=0.
  - Otherwise OKAY.
- Protocol check in WAIT: any change of address, read, write, writedata or byteenable versus the captured values sets proto_err. The transfer still completes using the captured values.
- proto_err clears only on reset.
- Counters increment only on OKAY completion and saturate (no wrap).
- byteenable=0 on a write: completes OKAY, memory unchanged, wr_count increments.

Decomposition:
- Package avalon_pkg holds:
  - resp_t enum (OKAY=2'b00, SLVERR=2'b10, DECODEERROR=2'b11)
  - state_t enum (IDLE, WAIT, ACK)
  - localparam for counter width (16)
- Sub-module avalon_slave_wait_fsm: state register, wait counter, capture registers and protocol comparison. It outputs waitrequest, an accept pulse and the captured command.
- The top level holds the memory array, byte-lane merge, response decode and counters.

Test Plan:
- Reset then write 0x10=0xDEADBEEF, WAIT_CYCLES=2 -> waitrequest low exactly 3 cycles after write seen; response=00; wr_count=1; read 0x10 returns 0xDEADBEEF.
- Write 0x20=0x11223344 then byteenable=4'b0101 write 0xAABBCCDD -> readback 0x11BB33DD; wr_count=2.
- WAIT_CYCLES=0 build: back-to-back writes then a read -> one stall cycle each; readdata valid in ACK cycle; rd_count=1.
- DEPTH=128, read address 0xC0 -> response=11, readdata=0, rd_count unchanged; write there leaves memory unchanged.
- read&write asserted together -> response=10, proto_err=1 and stays 1; changing address mid-WAIT on a later write -> the captured address is written.
- reset_n pulsed low during WAIT of a write -> waitrequest=1 immediately, target word still 0, counters 0; 65536 OKAY writes -> wr_count stays 16'hFFFF.

Source files
------------

// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon-MM slave memory.
package avalon_pkg;

  localparam int unsigned CntW = 16;

  typedef enum logic [1:0] {
    RespOkay      = 2'b00,
    RespSlvErr    = 2'b10,
    RespDecodeErr = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAck
  } state_t;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/avalon_slave_wait_fsm.sv
// Handshake FSM: captures a command, stalls WAIT_CYCLES cycles, then drops
// waitrequest for one cycle. Flags any master-side change while stalled.
module avalon_slave_wait_fsm
  import avalon_pkg::*;
#(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [AW-1:0]   address_i,
  input  logic            read_i,
  input  logic            write_i,
  input  logic [DW-1:0]   writedata_i,
  input  logic [DW/8-1:0] byteenable_i,
  output logic            waitrequest_o,
  output logic            accept_o,
  output logic            load_o,
  output logic [AW-1:0]   ld_addr_o,
  output logic            ld_read_o,
  output logic            ld_write_o,
  output logic [AW-1:0]   cap_addr_o,
  output logic            cap_read_o,
  output logic            cap_write_o,
  output logic [DW-1:0]   cap_wdata_o,
  output logic [DW/8-1:0] cap_be_o,
  output logic            viol_o
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW/8-1:0]   be_q, be_d;
  logic              wait_q;

  // State, counter, capture registers; waitrequest is registered from next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      wait_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wait_q  <= (state_d != StAck);
    end
  end

  // Next-state: capture in IDLE, count down in WAIT, single-cycle ACK.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    unique case (state_q)
      StIdle: begin
        if (read_i || write_i) begin
          addr_d  = address_i;
          rd_d    = read_i;
          wr_d    = write_i;
          wdata_d = writedata_i;
          be_d    = byteenable_i;
          cnt_d   = WaitInit;
          state_d = (WAIT_CYCLES == 0) ? StAck : StWait;
        end
      end
      StWait: begin
        if (cnt_q <= 4'd1) state_d = StAck;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs: load_o marks the edge entering ACK, where the top registers the response.
  always_comb begin
    waitrequest_o = wait_q;
    accept_o      = (state_q == StAck);
    load_o        = (state_d == StAck) && (state_q != StAck);
    ld_addr_o     = addr_d;
    ld_read_o     = rd_d;
    ld_write_o    = wr_d;
    cap_addr_o    = addr_q;
    cap_read_o    = rd_q;
    cap_write_o   = wr_q;
    cap_wdata_o   = wdata_q;
    cap_be_o      = be_q;
    viol_o        = (state_q == StWait) &&
                    ((address_i != addr_q) || (read_i != rd_q) || (write_i != wr_q) ||
                     (writedata_i != wdata_q) || (byteenable_i != be_q));
  end

endmodule

// File: rtl/avalon_slave_mem.sv
// Avalon-MM slave register-file memory with programmable wait states,
// response decode, sticky protocol-error flag and saturating transfer counters.
module avalon_slave_mem
  import avalon_pkg::*;
#(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 32,
  parameter int unsigned DEPTH       = 2**AW,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [AW-1:0]   address,
  input  logic            read,
  input  logic            write,
  input  logic [DW-1:0]   writedata,
  input  logic [DW/8-1:0] byteenable,
  output logic [DW-1:0]   readdata,
  output logic            waitrequest,
  output logic [1:0]      response,
  output logic            proto_err,
  output logic [CntW-1:0] wr_count,
  output logic [CntW-1:0] rd_count
);

  localparam int unsigned NumBytes = DW / 8;
  localparam int unsigned IdxW     = $clog2(DEPTH);

  logic            accept, load, viol;
  logic [AW-1:0]   ld_addr, cap_addr;
  logic            ld_read, ld_write, cap_read, cap_write;
  logic [DW-1:0]   cap_wdata;
  logic [DW/8-1:0] cap_be;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   readdata_q;
  resp_t           resp_q, resp_nxt;
  logic            perr_q;
  logic [CntW-1:0] wr_cnt_q, rd_cnt_q;
  logic            mem_we;

  avalon_slave_wait_fsm #(
    .AW          (AW),
    .DW          (DW),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_fsm (
    .clk_i         (clk),
    .rst_ni        (reset_n),
    .address_i     (address),
    .read_i        (read),
    .write_i       (write),
    .writedata_i   (writedata),
    .byteenable_i  (byteenable),
    .waitrequest_o (waitrequest),
    .accept_o      (accept),
    .load_o        (load),
    .ld_addr_o     (ld_addr),
    .ld_read_o     (ld_read),
    .ld_write_o    (ld_write),
    .cap_addr_o    (cap_addr),
    .cap_read_o    (cap_read),
    .cap_write_o   (cap_write),
    .cap_wdata_o   (cap_wdata),
    .cap_be_o      (cap_be),
    .viol_o        (viol)
  );

  // Response decode on the command that is about to enter ACK.
  always_comb begin
    resp_nxt = RespOkay;
    if (ld_read && ld_write)         resp_nxt = RespSlvErr;
    else if (32'(ld_addr) >= DEPTH)  resp_nxt = RespDecodeErr;
  end

  // Only an OKAY write reaches the array; SLVERR implies both flags so is excluded here.
  assign mem_we = accept && cap_write && (resp_q == RespOkay);

  // Memory array with per-byte write merge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < int'(NumBytes); b++) begin
        if (cap_be[b]) mem_q[cap_addr[IdxW-1:0]][b*8 +: 8] <= cap_wdata[b*8 +: 8];
      end
    end
  end

  // Response and read data are loaded on ACK entry; readdata only changes on reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_q     <= RespOkay;
      readdata_q <= '0;
    end else if (load) begin
      resp_q <= resp_nxt;
      if (ld_read && !ld_write) begin
        readdata_q <= (resp_nxt == RespOkay) ? mem_q[ld_addr[IdxW-1:0]] : '0;
      end
    end
  end

  // Sticky protocol error: mid-stall change or simultaneous read and write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perr_q <= 1'b0;
    else          perr_q <= perr_q | viol | (load && ld_read && ld_write);
  end

  // Saturating completion counters, OKAY transfers only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else if (accept && (resp_q == RespOkay)) begin
      if (cap_write)     wr_cnt_q <= sat_inc(wr_cnt_q);
      else if (cap_read) rd_cnt_q <= sat_inc(rd_cnt_q);
    end
  end

  assign readdata  = readdata_q;
  assign response  = resp_q;
  assign proto_err = perr_q;
  assign wr_count  = wr_cnt_q;
  assign rd_count  = rd_cnt_q;

endmodule

// File: tb/tb_avalon_slave_mem.sv
// Directed bench for avalon_slave_mem: three builds (WAIT_CYCLES=2, WAIT_CYCLES=0,
// DEPTH=128/WAIT_CYCLES=1), a vector table plus hand-written corner sequences.
module tb_avalon_slave_mem;

  logic        clk = 1'b0;
  logic        rst_n [3];
  logic [7:0]  addr  [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] wdata [3];
  logic [3:0]  be    [3];
  logic [31:0] rdata [3];
  logic        waitreq [3];
  logic [1:0]  resp  [3];
  logic        perr  [3];
  logic [15:0] wcnt  [3];
  logic [15:0] rcnt  [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  avalon_slave_mem u_dut0 (
    .clk (clk), .reset_n (rst_n[0]), .address (addr[0]), .read (rd[0]), .write (wr[0]),
    .writedata (wdata[0]), .byteenable (be[0]), .readdata (rdata[0]),
    .waitrequest (waitreq[0]), .response (resp[0]), .proto_err (perr[0]),
    .wr_count (wcnt[0]), .rd_count (rcnt[0])
  );

  avalon_slave_mem #(.WAIT_CYCLES(0)) u_dut1 (
    .clk (clk), .reset_n (rst_n[1]), .address (addr[1]), .read (rd[1]), .write (wr[1]),
    .writedata (wdata[1]), .byteenable (be[1]), .readdata (rdata[1]),
    .waitrequest (waitreq[1]), .response (resp[1]), .proto_err (perr[1]),
    .wr_count (wcnt[1]), .rd_count (rcnt[1])
  );

  avalon_slave_mem #(.DEPTH(128), .WAIT_CYCLES(1)) u_dut2 (
    .clk (clk), .reset_n (rst_n[2]), .address (addr[2]), .read (rd[2]), .write (wr[2]),
    .writedata (wdata[2]), .byteenable (be[2]), .readdata (rdata[2]),
    .waitrequest (waitreq[2]), .response (resp[2]), .proto_err (perr[2]),
    .wr_count (wcnt[2]), .rd_count (rcnt[2])
  );

  typedef struct {
    int          inst;
    logic        r;
    logic        w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  b;
    int          lat;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transfer: command driven at a negedge, held until the accepting edge.
  // lat counts negedges from presentation until waitrequest is seen low.
  task automatic xfer(input int i, input logic r, input logic w, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] b, output int lat,
                      output logic [31:0] rd_o, output logic [1:0] rs);
    @(negedge clk);
    addr[i] = a; rd[i] = r; wr[i] = w; wdata[i] = d; be[i] = b;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (waitreq[i] && lat < 40);
    rd_o = rdata[i];
    rs   = resp[i];
    @(posedge clk);
    #1;
    rd[i] = 1'b0; wr[i] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rdv;
    logic [1:0]  rsv;

    vt[0]  = '{0, 1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 3, 2'b00, 32'h0};
    vt[1]  = '{0, 1'b1, 1'b0, 8'h10, 32'h0,        4'hF, 3, 2'b00, 32'hDEADBEEF};
    vt[2]  = '{0, 1'b0, 1'b1, 8'h20, 32'h11223344, 4'hF, 3, 2'b00, 32'hDEADBEEF};
    vt[3]  = '{0, 1'b0, 1'b1, 8'h20, 32'hAABBCCDD, 4'h5, 3, 2'b00, 32'hDEADBEEF};
    vt[4]  = '{0, 1'b1, 1'b0, 8'h20, 32'h0,        4'h0, 3, 2'b00, 32'h11BB33DD};
    vt[5]  = '{0, 1'b0, 1'b1, 8'h21, 32'hCAFEF00D, 4'h0, 3, 2'b00, 32'h11BB33DD};
    vt[6]  = '{0, 1'b1, 1'b0, 8'h21, 32'h0,        4'hF, 3, 2'b00, 32'h0};
    vt[7]  = '{0, 1'b0, 1'b1, 8'hFF, 32'h12345678, 4'hF, 3, 2'b00, 32'h0};
    vt[8]  = '{0, 1'b1, 1'b0, 8'hFF, 32'h0,        4'hF, 3, 2'b00, 32'h12345678};
    vt[9]  = '{1, 1'b0, 1'b1, 8'h05, 32'h01020304, 4'hF, 1, 2'b00, 32'h0};
    vt[10] = '{1, 1'b0, 1'b1, 8'h06, 32'hA5A5A5A5, 4'hF, 1, 2'b00, 32'h0};
    vt[11] = '{1, 1'b1, 1'b0, 8'h05, 32'h0,        4'hF, 1, 2'b00, 32'h01020304};
    vt[12] = '{2, 1'b0, 1'b1, 8'h7F, 32'h0BADF00D, 4'hF, 2, 2'b00, 32'h0};
    vt[13] = '{2, 1'b1, 1'b0, 8'hC0, 32'h0,        4'hF, 2, 2'b11, 32'h0};
    vt[14] = '{2, 1'b0, 1'b1, 8'hC0, 32'hFFFFFFFF, 4'hF, 2, 2'b11, 32'h0};
    vt[15] = '{2, 1'b1, 1'b0, 8'h40, 32'h0,        4'hF, 2, 2'b00, 32'h0};
    vt[16] = '{2, 1'b1, 1'b0, 8'h7F, 32'h0,        4'hF, 2, 2'b00, 32'h0BADF00D};
    vt[17] = '{2, 1'b1, 1'b0, 8'h80, 32'h0,        4'hF, 2, 2'b11, 32'h0};

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; addr[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0; wdata[i] = '0; be[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_waitrequest", 32'(waitreq[0]), 32'h1);
    check("rst_readdata", rdata[0], 32'h0);
    check("rst_response", 32'(resp[0]), 32'h0);
    check("rst_proto_err", 32'(perr[0]), 32'h0);
    check("rst_wr_count", 32'(wcnt[0]), 32'h0);
    check("rst_rd_count", 32'(rcnt[0]), 32'h0);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 18; k++) begin
      xfer(vt[k].inst, vt[k].r, vt[k].w, vt[k].a, vt[k].d, vt[k].b, lat, rdv, rsv);
      check($sformatf("v%0d_latency", k), 32'(lat), 32'(vt[k].lat));
      check($sformatf("v%0d_response", k), 32'(rsv), 32'(vt[k].resp));
      check($sformatf("v%0d_readdata", k), rdv, vt[k].rdata);
    end

    check("i0_wr_count", 32'(wcnt[0]), 32'd5);
    check("i0_rd_count", 32'(rcnt[0]), 32'd4);
    check("i1_wr_count", 32'(wcnt[1]), 32'd2);
    check("i1_rd_count", 32'(rcnt[1]), 32'd1);
    check("i2_wr_count", 32'(wcnt[2]), 32'd1);
    check("i2_rd_count", 32'(rcnt[2]), 32'd2);
    check("i2_proto_err_clean", 32'(perr[2]), 32'h0);

    // read and write together: SLVERR, sticky proto_err, no access
    xfer(0, 1'b1, 1'b1, 8'h10, 32'h0, 4'hF, lat, rdv, rsv);
    check("rw_latency", 32'(lat), 32'd3);
    check("rw_response", 32'(rsv), 32'h2);
    check("rw_proto_err", 32'(perr[0]), 32'h1);
    xfer(0, 1'b1, 1'b0, 8'h10, 32'h0, 4'hF, lat, rdv, rsv);
    check("rw_mem_untouched", rdv, 32'hDEADBEEF);
    check("rw_proto_err_sticky", 32'(perr[0]), 32'h1);
    check("rw_wr_count", 32'(wcnt[0]), 32'd5);
    check("rw_rd_count", 32'(rcnt[0]), 32'd5);

    // reset asserted while a write is stalled in WAIT
    @(negedge clk);
    addr[0] = 8'h30; wr[0] = 1'b1; wdata[0] = 32'h99; be[0] = 4'hF;
    @(negedge clk);
    rst_n[0] = 1'b0;
    #1;
    check("rstw_waitrequest", 32'(waitreq[0]), 32'h1);
    check("rstw_wr_count", 32'(wcnt[0]), 32'h0);
    check("rstw_rd_count", 32'(rcnt[0]), 32'h0);
    check("rstw_proto_err", 32'(perr[0]), 32'h0);
    wr[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    xfer(0, 1'b1, 1'b0, 8'h30, 32'h0, 4'hF, lat, rdv, rsv);
    check("rstw_target_word", rdv, 32'h0);
    xfer(0, 1'b1, 1'b0, 8'h10, 32'h0, 4'hF, lat, rdv, rsv);
    check("rstw_mem_cleared", rdv, 32'h0);
    check("rstw_wr_count_after", 32'(wcnt[0]), 32'h0);

    // address changed mid-WAIT: captured address is the one written
    @(negedge clk);
    addr[2] = 8'h10; wr[2] = 1'b1; wdata[2] = 32'h77; be[2] = 4'hF;
    @(posedge clk);
    #1;
    addr[2] = 8'h11;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (waitreq[2] && lat < 40);
    check("chg_response", 32'(resp[2]), 32'h0);
    @(posedge clk);
    #1;
    wr[2] = 1'b0;
    check("chg_proto_err", 32'(perr[2]), 32'h1);
    xfer(2, 1'b1, 1'b0, 8'h10, 32'h0, 4'hF, lat, rdv, rsv);
    check("chg_captured_addr", rdv, 32'h77);
    xfer(2, 1'b1, 1'b0, 8'h11, 32'h0, 4'hF, lat, rdv, rsv);
    check("chg_other_addr", rdv, 32'h0);
    check("chg_wr_count", 32'(wcnt[2]), 32'd2);

    // counter saturation, preloaded near the top
    @(negedge clk);
    force u_dut1.wr_cnt_q = 16'hFFFE;
    #1;
    release u_dut1.wr_cnt_q;
    xfer(1, 1'b0, 1'b1, 8'h07, 32'h1, 4'hF, lat, rdv, rsv);
    check("sat_reach_max", 32'(wcnt[1]), 32'hFFFF);
    xfer(1, 1'b0, 1'b1, 8'h08, 32'h2, 4'hF, lat, rdv, rsv);
    check("sat_hold_max", 32'(wcnt[1]), 32'hFFFF);
    xfer(1, 1'b0, 1'b1, 8'h09, 32'h3, 4'hF, lat, rdv, rsv);
    check("sat_hold_max2", 32'(wcnt[1]), 32'hFFFF);
    check("sat_rd_count", 32'(rcnt[1]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
